// File: rtl/audio_pkg.sv
// Shared audio definitions: receiver state encoding and I2S word-select levels.
package audio_pkg;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } rx_state_e;

    localparam logic LRCK_LEFT  = 1'b0;
    localparam logic LRCK_RIGHT = 1'b1;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for one asynchronous input, with a registered-level
// rising-edge pulse (one clk wide) derived from the synchronized level.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q;
    logic level_q;
    logic prev_q;

    // NOTE: flops use non-blocking assignments so every stage samples the
    // pre-edge value of its neighbour, forming a true shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            meta_q  <= async_i;
            level_q <= meta_q;
            prev_q  <= level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~prev_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bck/lrck/adata in clk and emits stereo sample pairs.
// Optional sticky frame-length check is enabled with macro I2S_RX_FRAME_CHECK_EN.
module i2s_rx
    import audio_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int SLOT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_adc_bck,
    input  logic              i_adc_lrck,
    input  logic              i_adc_adata,
    output logic [DATA_W-1:0] o_left,
    output logic [DATA_W-1:0] o_right,
    output logic              o_valid,
    output logic              o_err
);

    localparam int                 SLOT_CW   = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
    localparam logic [SLOT_CW-1:0] SLOT_LAST = SLOT_CW'(SLOT_W - 1);

    logic bit_evt;
    logic bck_lvl;
    logic lrck_lvl;
    logic lrck_rise;
    logic adata_lvl;
    logic adata_rise;
    logic unused_sync;

    sync_edge u_sync_bck (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (i_adc_bck),
        .level_o (bck_lvl),
        .rise_o  (bit_evt)
    );

    sync_edge u_sync_lrck (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (i_adc_lrck),
        .level_o (lrck_lvl),
        .rise_o  (lrck_rise)
    );

    sync_edge u_sync_adata (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (i_adc_adata),
        .level_o (adata_lvl),
        .rise_o  (adata_rise)
    );

    assign unused_sync = &{1'b0, bck_lvl, lrck_rise, adata_rise};

    rx_state_e          state_q, state_d;
    logic               run;
    logic               lrck_prev_q, lrck_prev_d;
    logic               prev_vld_q, prev_vld_d;
    logic               transition;
    logic [SLOT_CW-1:0] slot_q, slot_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [DATA_W-1:0]  word_fin;
    logic [DATA_W-1:0]  left_hold_q, left_hold_d;
    logic               left_vld_q, left_vld_d;
    logic [DATA_W-1:0]  left_q, left_d;
    logic [DATA_W-1:0]  right_q, right_d;
    logic               valid_q, valid_d;

    // The very first bit event after reset only records lrck; it cannot be a transition.
    assign transition = bit_evt & prev_vld_q & (lrck_lvl != lrck_prev_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (transition) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        run = 1'b0;
        case (state_q)
            SYNC:    run = 1'b0;
            RUN:     run = 1'b1;
            default: run = 1'b0;
        endcase
    end

    // Slot k lands at bit DATA_W-1-k; slots past DATA_W match nothing and are dropped.
    always_comb begin
        word_fin = shreg_q;
        for (int b = 0; b < DATA_W; b++) begin
            if (slot_q == SLOT_CW'(DATA_W - 1 - b)) begin
                word_fin[b] = adata_lvl;
            end
        end
    end

    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        lrck_prev_d = lrck_prev_q;
        prev_vld_d  = prev_vld_q;
        slot_d      = slot_q;
        shreg_d     = shreg_q;
        left_hold_d = left_hold_q;
        left_vld_d  = left_vld_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = 1'b0;

        if (bit_evt) begin
            lrck_prev_d = lrck_lvl;
            prev_vld_d  = 1'b1;
            if (transition) begin
                // The transition bit is still the last slot of the channel that ended.
                slot_d  = '0;
                shreg_d = '0;
                if (lrck_prev_q == LRCK_LEFT) begin
                    left_hold_d = word_fin;
                    left_vld_d  = run;
                end else begin
                    if (left_vld_q && run) begin
                        left_d  = left_hold_q;
                        right_d = word_fin;
                        valid_d = 1'b1;
                    end
                    left_vld_d = 1'b0;
                end
            end else begin
                shreg_d = word_fin;
                if (slot_q != SLOT_LAST) begin
                    slot_d = slot_q + SLOT_CW'(1);
                end
            end
        end
    end

    // NOTE: the data-holding registers are reset along with control so a
    // mid-word reset can never leak a stale half word to the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lrck_prev_q <= 1'b0;
            prev_vld_q  <= 1'b0;
            slot_q      <= '0;
            shreg_q     <= '0;
            left_hold_q <= '0;
            left_vld_q  <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            lrck_prev_q <= lrck_prev_d;
            prev_vld_q  <= prev_vld_d;
            slot_q      <= slot_d;
            shreg_q     <= shreg_d;
            left_hold_q <= left_hold_d;
            left_vld_q  <= left_vld_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
        end
    end

    assign o_left  = left_q;
    assign o_right = right_q;
    assign o_valid = valid_q;

`ifdef I2S_RX_FRAME_CHECK_EN
    logic ovf_q, ovf_d;
    logic err_q, err_d;

    // ovf remembers that a channel ran past SLOT_W slots, since the counter saturates.
    always_comb begin
        ovf_d = ovf_q;
        err_d = err_q;
        if (bit_evt) begin
            if (transition) begin
                ovf_d = 1'b0;
                if (run && (ovf_q || (slot_q != SLOT_LAST))) begin
                    err_d = 1'b1;
                end
            end else if (slot_q == SLOT_LAST) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule
